// File: rtl/apb_cfg_pkg.sv
// Shared types and helpers for the APB configuration-port arbiter.
`ifndef APB_ADDR_WIDTH
`define APB_ADDR_WIDTH 32
`endif
`ifndef APB_DATA_WIDTH
`define APB_DATA_WIDTH 32
`endif

package apb_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2
  } apb_st_e;

  // Index width for n requesters; a single requester still needs one bit.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin winner select with a rotating priority pointer.
// The pointer moves to one past the winner only when the grant is accepted.
module rr_arbiter
  import apb_cfg_pkg::*;
#(
  parameter int N  = 2,
  parameter int IW = idx_width(N)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [N-1:0]  req,
  input  logic          accept,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx,
  output logic          any_req
);

  logic [IW-1:0] ptr;
  logic [IW-1:0] scan;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    any_req   = 1'b0;
    scan      = '0;
    for (int off = 0; off < N; off++) begin
      scan = IW'((int'(ptr) + off) % N);
      if (!any_req && req[scan]) begin
        any_req     = 1'b1;
        grant[scan] = 1'b1;
        grant_idx   = scan;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (accept) begin
      ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
    end
  end

endmodule

// File: rtl/apb_cfg_arbiter.sv
// Shares one APB master port between N_REQ single-command requesters,
// granting round-robin and returning read data or a timeout error.
//
//   state     | meaning
//   ----------+------------------------------------------------------
//   ST_IDLE   | no transfer; winner sees req_ready, accept latches cmd
//   ST_SETUP  | psel=1 penable=0, exactly one cycle
//   ST_ACCESS | psel=1 penable=1 until pready or the wait timer expires
module apb_cfg_arbiter
  import apb_cfg_pkg::*;
#(
  parameter int N_REQ   = 2,
  parameter int ADDR_W  = `APB_ADDR_WIDTH,
  parameter int DATA_W  = `APB_DATA_WIDTH,
  parameter int TIMEOUT = 256
) (
  input  logic                      pclk,
  input  logic                      presetn,
  input  logic [N_REQ-1:0]          req_valid,
  output logic [N_REQ-1:0]          req_ready,
  input  logic [N_REQ-1:0]          req_write,
  input  logic [N_REQ*ADDR_W-1:0]   req_addr,
  input  logic [N_REQ*DATA_W-1:0]   req_wdata,
  output logic [N_REQ-1:0]          rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic [ADDR_W-1:0]         paddr,
  output logic [DATA_W-1:0]         pwdata,
  output logic                      pwrite,
  output logic                      psel,
  output logic                      penable,
  input  logic                      pready,
  input  logic [DATA_W-1:0]         prdata
);

  localparam int IW = idx_width(N_REQ);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]    WAIT_LOAD = (TIMEOUT > 1) ? TW'(TIMEOUT - 1) : '0;
  localparam logic [N_REQ-1:0] ONE_HOT0  = N_REQ'(1);

  apb_st_e          state;
  logic [IW-1:0]    owner;
  logic [IW-1:0]    win_idx;
  logic [N_REQ-1:0] win;
  logic             any_req;
  logic             accept;
  logic [TW-1:0]    wait_cnt;
  logic             wait_exp;

  rr_arbiter #(.N(N_REQ), .IW(IW)) u_arb (
    .clk       (pclk),
    .rst_n     (presetn),
    .req       (req_valid),
    .accept    (accept),
    .grant     (win),
    .grant_idx (win_idx),
    .any_req   (any_req)
  );

  assign accept    = (state == ST_IDLE) && any_req;
  assign req_ready = accept ? win : '0;
  // Down-counter reaching zero marks the last ACCESS cycle allowed without pready.
  assign wait_exp  = (TIMEOUT != 0) && (wait_cnt == '0);

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state     <= ST_IDLE;
      owner     <= '0;
      paddr     <= '0;
      pwdata    <= '0;
      pwrite    <= 1'b0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      wait_cnt  <= '0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      rsp_valid <= '0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            paddr  <= req_addr[win_idx*ADDR_W +: ADDR_W];
            pwdata <= req_wdata[win_idx*DATA_W +: DATA_W];
            pwrite <= req_write[win_idx];
            owner  <= win_idx;
            psel   <= 1'b1;
            state  <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          penable  <= 1'b1;
          wait_cnt <= WAIT_LOAD;
          state    <= ST_ACCESS;
        end
        ST_ACCESS: begin
          // pready wins over an expiring timer in the same cycle.
          if (pready || wait_exp) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            state     <= ST_IDLE;
            rsp_valid <= ONE_HOT0 << owner;
            rsp_err   <= !pready;
            rsp_rdata <= (pready && !pwrite) ? prdata : '0;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
